// File: rtl/pool_pkg.sv
// ============================================================================
// Module   : pool_pkg
// Purpose  : Shared encodings, control states and helper functions for pooling.
// Revision : 1.0 - initial multi-channel window-counted release
// ============================================================================
`default_nettype none

package pool_pkg;

  localparam logic POOL_MODE_MAX = 1'b0;
  localparam logic POOL_MODE_AVG = 1'b1;

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_FULL = 1'b1
  } pool_state_t;

  // Enough headroom to sum WIN_MAX samples without overflow.
  function automatic int acc_width(input int num_width, input int win_max);
    return num_width + $clog2(win_max);
  endfunction

  // Clamp a wide signed value into the signed range of an nw-bit sample.
  function automatic logic signed [63:0] sat_num(input logic signed [63:0] v,
                                                 input int nw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (nw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pool_lane.sv
// ============================================================================
// Module   : pool_lane
// Purpose  : One lane of the pool: accumulator, max/add fold, shift, saturate.
//            Average datapath present only when POOL_AVG_EN is defined.
// Revision : 1.0 - initial multi-channel window-counted release
// ============================================================================
`default_nettype none

module pool_lane
  import pool_pkg::*;
#(
  parameter int NUM_WIDTH = 16,
  parameter int WIN_MAX   = 16,
  parameter int SHIFT_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept,
  input  logic                 first,
  input  logic                 done,
  input  logic                 mode,
  input  logic [SHIFT_W-1:0]   shift,
  input  logic [NUM_WIDTH-1:0] in_data,
  output logic [NUM_WIDTH-1:0] out_data
);

`ifdef POOL_AVG_EN
  localparam int ACC_W = acc_width(NUM_WIDTH, WIN_MAX);
`else
  localparam int ACC_W = NUM_WIDTH;
`endif

  logic signed [ACC_W-1:0]     r_acc;
  logic signed [ACC_W-1:0]     w_in_ext;
  logic signed [ACC_W-1:0]     w_fold;
  logic signed [ACC_W-1:0]     w_next;
  logic        [NUM_WIDTH-1:0] r_out;
  logic        [NUM_WIDTH-1:0] w_res;

  assign w_in_ext = ACC_W'(signed'(in_data));

  always_comb begin
    w_fold = (w_in_ext > r_acc) ? w_in_ext : r_acc;
`ifdef POOL_AVG_EN
    if (mode == POOL_MODE_AVG) w_fold = r_acc + w_in_ext;
`endif
  end

  // First beat of a window seeds the accumulator instead of folding into it.
  assign w_next = first ? w_in_ext : w_fold;

`ifdef POOL_AVG_EN
  logic signed [ACC_W-1:0] w_shifted;
  assign w_shifted = w_next >>> shift;
  assign w_res = (mode == POOL_MODE_AVG) ? NUM_WIDTH'(sat_num(64'(w_shifted), NUM_WIDTH))
                                         : w_next[NUM_WIDTH-1:0];
`else
  logic w_unused_lane;
  assign w_unused_lane = ^{mode, shift};
  assign w_res = w_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_out <= '0;
    end else begin
      if (accept) r_acc <= w_next;
      if (done)   r_out <= w_res;
    end
  end

  assign out_data = r_out;

endmodule

`default_nettype wire

// File: rtl/pool_array.sv
// ============================================================================
// Module   : pool_array
// Purpose  : CHANNELS-wide window-counted max/average pool with valid/ready.
//            Define POOL_AVG_EN to build in average mode.
// Revision : 1.0 - initial multi-channel window-counted release
// ============================================================================
`default_nettype none

module pool_array
  import pool_pkg::*;
#(
  parameter  int NUM_WIDTH = 16,
  parameter  int CHANNELS  = 4,
  parameter  int WIN_MAX   = 16,
  localparam int WIN_W     = $clog2(WIN_MAX + 1),
  localparam int SHIFT_RAW = $clog2($clog2(WIN_MAX) + 1),
  localparam int SHIFT_W   = (SHIFT_RAW < 1) ? 1 : SHIFT_RAW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          restart,
  input  logic                          cfg_mode,
  input  logic [WIN_W-1:0]              cfg_win,
  input  logic [SHIFT_W-1:0]            cfg_shift,
  input  logic [CHANNELS*NUM_WIDTH-1:0] up_data,
  input  logic                          up_valid,
  output logic                          up_ready,
  output logic [CHANNELS*NUM_WIDTH-1:0] dn_data,
  output logic                          dn_valid,
  input  logic                          dn_ready
);

  localparam logic [WIN_W-1:0] c_win_max = WIN_W'(WIN_MAX);
  localparam logic [WIN_W-1:0] c_one     = WIN_W'(1);

  pool_state_t        r_state;
  pool_state_t        w_state_nxt;
  logic [WIN_W-1:0]   r_cnt;
  logic [WIN_W-1:0]   r_win;
  logic [WIN_W-1:0]   w_cnt_cur;
  logic [WIN_W-1:0]   w_win_cfg;
  logic [WIN_W-1:0]   w_win;
  logic               r_mode;
  logic               w_cfg_mode;
  logic               w_mode;
  logic [SHIFT_W-1:0] r_shift;
  logic [SHIFT_W-1:0] w_cfg_shift;
  logic [SHIFT_W-1:0] w_shift;
  logic               w_accept;
  logic               w_first;
  logic               w_done;

`ifdef POOL_AVG_EN
  assign w_cfg_mode  = cfg_mode;
  assign w_cfg_shift = cfg_shift;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{cfg_mode, cfg_shift};
  assign w_cfg_mode   = POOL_MODE_MAX;
  assign w_cfg_shift  = '0;
`endif

  assign dn_valid = (r_state == ST_FULL);
  assign up_ready = ~dn_valid | dn_ready;
  assign w_accept = up_valid & up_ready;

  always_comb begin
    w_win_cfg = cfg_win;
    if (cfg_win == '0)           w_win_cfg = c_one;
    else if (cfg_win > c_win_max) w_win_cfg = c_win_max;
  end

  // A beat that opens a window (or coincides with restart) runs on live config.
  assign w_first   = restart | (r_cnt == '0);
  assign w_cnt_cur = restart ? '0 : r_cnt;
  assign w_win     = w_first ? w_win_cfg   : r_win;
  assign w_mode    = w_first ? w_cfg_mode  : r_mode;
  assign w_shift   = w_first ? w_cfg_shift : r_shift;
  assign w_done    = w_accept & (w_cnt_cur == (w_win - c_one));

  always_comb begin
    w_state_nxt = r_state;
    if (w_done)                                 w_state_nxt = ST_FULL;
    else if ((r_state == ST_FULL) && dn_ready)  w_state_nxt = ST_ACC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACC;
      r_cnt   <= '0;
      r_win   <= c_one;
      r_mode  <= POOL_MODE_MAX;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt <= w_done ? '0 : (w_cnt_cur + c_one);
        if (w_first) begin
          r_win   <= w_win_cfg;
          r_mode  <= w_cfg_mode;
          r_shift <= w_cfg_shift;
        end
      end else if (restart) begin
        r_cnt <= '0;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    pool_lane #(
      .NUM_WIDTH (NUM_WIDTH),
      .WIN_MAX   (WIN_MAX),
      .SHIFT_W   (SHIFT_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .accept   (w_accept),
      .first    (w_first),
      .done     (w_done),
      .mode     (w_mode),
      .shift    (w_shift),
      .in_data  (up_data[k*NUM_WIDTH +: NUM_WIDTH]),
      .out_data (dn_data[k*NUM_WIDTH +: NUM_WIDTH])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_pool_array.sv
// ============================================================================
// Module   : tb_pool_array
// Purpose  : Directed self-checking bench for pool_array (2 lanes, 16-bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pool_array;

  localparam int NW = 16;
  localparam int CH = 2;
  localparam int WM = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          restart = 1'b0;
  logic          cfg_mode = 1'b0;
  logic [4:0]    cfg_win = 5'd1;
  logic [2:0]    cfg_shift = 3'd0;
  logic [31:0]   up_data = '0;
  logic          up_valid = 1'b0;
  logic          up_ready;
  logic [31:0]   dn_data;
  logic          dn_valid;
  logic          dn_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  pool_array #(.NUM_WIDTH(NW), .CHANNELS(CH), .WIN_MAX(WM)) dut (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .cfg_mode  (cfg_mode),
    .cfg_win   (cfg_win),
    .cfg_shift (cfg_shift),
    .up_data   (up_data),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .dn_data   (dn_data),
    .dn_valid  (dn_valid),
    .dn_ready  (dn_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pk(input logic signed [15:0] l0,
                                     input logic signed [15:0] l1);
    return {l1, l0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat for one clock edge; returns 1 time unit after the edge.
  task automatic beat(input logic signed [15:0] l0, input logic signed [15:0] l1);
    up_data  = pk(l0, l1);
    up_valid = 1'b1;
    @(posedge clk);
    #1;
    up_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_dn_valid", {31'd0, dn_valid}, 32'd0);
    chk("reset_dn_data", dn_data, 32'd0);
    chk("reset_up_ready", {31'd0, up_ready}, 32'd1);

    // Max, window of 4
    cfg_mode = 1'b0; cfg_win = 5'd4;
    beat(16'sd3, -16'sd1);
    beat(-16'sd7, -16'sd9);
    beat(16'sd12, -16'sd2);
    chk("max4_not_early", {31'd0, dn_valid}, 32'd0);
    beat(16'sd5, -16'sd4);
    chk("max4_valid", {31'd0, dn_valid}, 32'd1);
    chk("max4_data", dn_data, pk(16'sd12, -16'sd1));
    idle();
    chk("max4_drain", {31'd0, dn_valid}, 32'd0);

    // cfg_win = 0 behaves as window of 1
    cfg_win = 5'd0;
    beat(16'sd7, 16'sd8);
    chk("win0_valid", {31'd0, dn_valid}, 32'd1);
    chk("win0_data", dn_data, pk(16'sd7, 16'sd8));
    idle();

    // Window size change mid-window is ignored
    cfg_win = 5'd3;
    beat(16'sd1, 16'sd1);
    cfg_win = 5'd1;
    beat(16'sd2, 16'sd2);
    chk("cfgchg_not_early", {31'd0, dn_valid}, 32'd0);
    beat(16'sd3, 16'sd0);
    chk("cfgchg_valid", {31'd0, dn_valid}, 32'd1);
    chk("cfgchg_data", dn_data, pk(16'sd3, 16'sd2));
    idle();

    // Restart coinciding with a beat starts a new window with it
    cfg_win = 5'd4;
    beat(16'sd9, 16'sd9);
    beat(16'sd8, 16'sd8);
    restart = 1'b1;
    beat(16'sd1, 16'sd1);
    restart = 1'b0;
    beat(16'sd2, 16'sd2);
    beat(16'sd3, 16'sd3);
    chk("restart_not_early", {31'd0, dn_valid}, 32'd0);
    beat(16'sd4, 16'sd4);
    chk("restart_valid", {31'd0, dn_valid}, 32'd1);
    chk("restart_data", dn_data, pk(16'sd4, 16'sd4));
    // Restart while a result is held leaves it intact
    dn_ready = 1'b0;
    restart  = 1'b1;
    idle();
    restart  = 1'b0;
    chk("restart_hold_valid", {31'd0, dn_valid}, 32'd1);
    chk("restart_hold_data", dn_data, pk(16'sd4, 16'sd4));
    chk("restart_hold_ready", {31'd0, up_ready}, 32'd0);
    dn_ready = 1'b1;
    idle();
    chk("restart_drain", {31'd0, dn_valid}, 32'd0);

    // Back-pressure with window of 1
    cfg_win  = 5'd1;
    dn_ready = 1'b0;
    up_data  = pk(16'sd100, -16'sd100);
    up_valid = 1'b1;
    idle();
    chk("bp_first_valid", {31'd0, dn_valid}, 32'd1);
    chk("bp_first_ready", {31'd0, up_ready}, 32'd0);
    chk("bp_first_data", dn_data, pk(16'sd100, -16'sd100));
    up_data = pk(16'sd101, -16'sd101);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("bp_hold_data", dn_data, pk(16'sd100, -16'sd100));
      chk("bp_hold_ready", {31'd0, up_ready}, 32'd0);
    end
    dn_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, up_ready}, 32'd1);
    idle();
    chk("bp_r1_valid", {31'd0, dn_valid}, 32'd1);
    chk("bp_r1_data", dn_data, pk(16'sd101, -16'sd101));
    up_data = pk(16'sd102, -16'sd102);
    idle();
    chk("bp_r2_data", dn_data, pk(16'sd102, -16'sd102));
    up_valid = 1'b0;
    idle();
    chk("bp_drain_valid", {31'd0, dn_valid}, 32'd0);
    chk("bp_drain_data", dn_data, pk(16'sd102, -16'sd102));

`ifdef POOL_AVG_EN
    // Average, window 4, shift 2
    cfg_mode = 1'b1; cfg_win = 5'd4; cfg_shift = 3'd2;
    beat(16'sd10, -16'sd1);
    beat(16'sd11, -16'sd1);
    beat(-16'sd3, -16'sd1);
    beat(16'sd2, -16'sd2);
    chk("avg4_valid", {31'd0, dn_valid}, 32'd1);
    chk("avg4_data", dn_data, pk(16'sd5, -16'sd2));
    idle();
    // Saturation, window 2, shift 0
    cfg_win = 5'd2; cfg_shift = 3'd0;
    beat(16'sd30000, -16'sd30000);
    beat(16'sd30000, -16'sd30000);
    chk("avgsat_data", dn_data, pk(16'sh7FFF, 16'sh8000));
    idle();
    cfg_mode = 1'b0;
`endif

    // Asynchronous reset mid-window
    cfg_win = 5'd4;
    beat(16'sd50, 16'sd50);
    beat(16'sd60, 16'sd60);
    beat(16'sd70, 16'sd70);
    #3 rst = 1'b1;
    #1;
    chk("arst_dn_valid", {31'd0, dn_valid}, 32'd0);
    chk("arst_dn_data", dn_data, 32'd0);
    #1 rst = 1'b0;
    beat(16'sd1, -16'sd5);
    beat(16'sd2, -16'sd6);
    beat(16'sd3, -16'sd7);
    chk("arst_not_early", {31'd0, dn_valid}, 32'd0);
    beat(16'sd4, -16'sd8);
    chk("arst_valid", {31'd0, dn_valid}, 32'd1);
    chk("arst_data", dn_data, pk(16'sd4, -16'sd5));
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
